// File: rtl/regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pkg
// Shared CPU package for the register file slice.
// Holds the default datapath widths used by the register file and its
// scoreboard, plus the read-source selection type and helper shared by
// both read ports.
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_sb_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;

    // Where a read port takes its value from in the current cycle.
    typedef enum logic [1:0] {
        RD_SRC_ZERO   = 2'd0,
        RD_SRC_BYPASS = 2'd1,
        RD_SRC_MEM    = 2'd2
    } rd_src_e;

    // A hardwired-zero address wins over a same-cycle write, and a same-cycle
    // write wins over the stored value (write-first behaviour).
    function automatic rd_src_e rd_src_sel(input logic is_zero, input logic bypass_hit);
        rd_src_e sel;
        if (is_zero) begin
            sel = RD_SRC_ZERO;
        end else if (bypass_hit) begin
            sel = RD_SRC_BYPASS;
        end else begin
            sel = RD_SRC_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register. An issue marks its destination
// pending, a writeback clears it. Issue wins when both hit the same register
// in the same cycle.
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   wr_en, wr_addr      - writeback, clears busy[wr_addr]
//   iss_en, iss_addr    - issue, sets busy[iss_addr]
//   busy_next           - busy vector as it will be after the coming edge
//   iss_err             - registered pulse: issue to a register still busy
//   busy_cnt            - registered population count of the busy bits
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [(2**ADDR_W)-1:0]   busy_next,
    output logic                     iss_err,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic             iss_act;
    logic             err_next;
    logic [ADDR_W:0]  cnt_next;

    // Issues to the hardwired zero register are dropped so it never shows busy.
    assign iss_act = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // Next busy vector: clear first, then set, so a same-cycle issue to the
    // register being written back leaves it busy. The error only fires when
    // the target was busy and is not being released by this cycle's writeback.
    always_comb begin
        busy_next = busy_q;
        err_next  = 1'b0;
        cnt_next  = '0;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (iss_act) begin
            busy_next[iss_addr] = 1'b1;
        end
        err_next = iss_act && busy_q[iss_addr] && !(wr_en && (wr_addr == iss_addr));
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    // Busy bits, error pulse and count all move together on the clock edge,
    // so busy_cnt always matches the busy vector held in busy_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= '0;
            iss_err  <= 1'b0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_next;
            iss_err  <= err_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with two registered read ports, one write port with
// write-first bypass, an optional hardwired-zero register 0, and a busy-bit
// scoreboard for tracking pending destinations.
// Ports:
//   clk, reset                  - clock and asynchronous active-high reset
//   rd_en                       - read strobe for both read ports
//   rd_addr1, rd_addr2          - read addresses
//   rd_data1, rd_data2          - registered read data
//   rd_busy1, rd_busy2          - registered busy state of each read address
//   rd_valid                    - one-cycle pulse when read outputs update
//   wr_en, wr_addr, wr_data     - writeback port
//   iss_en, iss_addr            - marks a destination register pending
//   iss_err                     - pulse: issue to an already-busy register
//   busy_cnt                    - number of busy registers
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_err,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_next;
    logic              wr_act;
    rd_src_e           src1;
    rd_src_e           src2;
    logic [DATA_W-1:0] rd_val1;
    logic [DATA_W-1:0] rd_val2;

    // Writes to the hardwired zero register never reach storage.
    assign wr_act = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .busy_next (busy_next),
        .iss_err   (iss_err),
        .busy_cnt  (busy_cnt)
    );

    // Read source selection for each port; the bypass makes a read in the same
    // cycle as a write to the same register observe the new value.
    always_comb begin
        src1    = rd_src_sel((ZERO_REG != 0) && (rd_addr1 == '0), wr_en && (wr_addr == rd_addr1));
        src2    = rd_src_sel((ZERO_REG != 0) && (rd_addr2 == '0), wr_en && (wr_addr == rd_addr2));
        rd_val1 = mem[rd_addr1];
        rd_val2 = mem[rd_addr2];
        case (src1)
            RD_SRC_ZERO:   rd_val1 = '0;
            RD_SRC_BYPASS: rd_val1 = wr_data;
            default:       rd_val1 = mem[rd_addr1];
        endcase
        case (src2)
            RD_SRC_ZERO:   rd_val2 = '0;
            RD_SRC_BYPASS: rd_val2 = wr_data;
            default:       rd_val2 = mem[rd_addr2];
        endcase
    end

    // Register storage; reset clears every entry so stale data never leaks
    // across a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_act) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read output registers. Data and busy state hold while rd_en is low;
    // rd_valid follows rd_en by one cycle. Busy is taken from the post-edge
    // scoreboard value so a same-cycle clear or set is already reflected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_busy1 <= 1'b0;
            rd_busy2 <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data1 <= rd_val1;
                rd_data2 <= rd_val2;
                rd_busy1 <= busy_next[rd_addr1];
                rd_busy2 <= busy_next[rd_addr2];
            end
        end
    end

endmodule
